// File: rtl/pwm_output_stage.sv
// rtl/pwm_output_stage.sv - PID word to PWM duty converter with period-boundary double buffering
module pwm_output_stage #(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk_in_i,
    input  logic             reset_n_i,
    input  logic             clk_en_i,
    input  logic             enable_i,
    input  logic             man_control_i,
    input  logic [15:0]      pid_i,
    input  logic [CNT_W-1:0] man_duty_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_min_i,
    input  logic [CNT_W-1:0] duty_max_i,
    output logic             pwm_o,
    output logic             period_done_o,
    output logic [CNT_W-1:0] duty_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] per_sh, per_sh_nx;
    logic [CNT_W-1:0] duty_sh, duty_sh_nx;
    logic [CNT_W-1:0] duty_calc;
    logic             done_nx, pwm_nx;

    logic [CNT_W-1:0] per_in, scaled, clamp_lo, clamp_hi, src, calc_nx;

    // Duty target: scale the controller word to the period, clamp, then limit to one full period.
    always_comb begin
        per_in   = (period_i < MIN_P) ? MIN_P : period_i;
        scaled   = CNT_W'(((CNT_W+16)'(pid_i) * (CNT_W+16)'(per_in)) >> 16);
        clamp_lo = (scaled < duty_min_i) ? duty_min_i : scaled;
        clamp_hi = (clamp_lo > duty_max_i) ? duty_max_i : clamp_lo;
        src      = man_control_i ? man_duty_i : clamp_hi;
        calc_nx  = (src > per_in) ? per_in : src;
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        per_sh_nx  = per_sh;
        duty_sh_nx = duty_sh;
        done_nx    = 1'b0;
        pwm_nx     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (enable_i && clk_en_i) begin
                    per_sh_nx  = per_in;
                    duty_sh_nx = duty_calc;
                    state_nx   = RUN;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    // Disable aborts the period outright; the restart begins from count zero.
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    pwm_nx = (cnt < duty_sh);
                    if (clk_en_i) begin
                        if (cnt == per_sh - ONE) begin
                            cnt_nx     = '0;
                            per_sh_nx  = per_in;
                            duty_sh_nx = duty_calc;
                            done_nx    = 1'b1;
                        end else begin
                            cnt_nx = cnt + ONE;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            cnt           <= '0;
            per_sh        <= MIN_P;
            duty_sh       <= '0;
            duty_calc     <= '0;
            pwm_o         <= 1'b0;
            period_done_o <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            per_sh        <= per_sh_nx;
            duty_sh       <= duty_sh_nx;
            duty_calc     <= calc_nx;
            pwm_o         <= pwm_nx;
            period_done_o <= done_nx;
        end
    end

    assign duty_o = duty_sh;

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
Downstream consumer of the PID controller output: converts the 16-bit pid_o word into a PWM duty cycle on a single output pin. It scales the controller word to the current PWM period, clamps the result to programmable limits, and double-buffers period and duty so that changes take effect only at period boundaries. It emits a per-period strobe that the control loop uses to pace sensor sampling and PID updates.

Parameters:
CNT_W, 16, width of period/duty counter and all count-valued ports
MIN_PERIOD, 2, smallest period ever loaded; smaller period_i values are forced to this

Ports:
clk_in_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
clk_en_i  in  1  PWM tick enable; the counter advances only on clocks where this is 1
enable_i  in  1  1 = run PWM, 0 = output forced low, counter idle
man_control_i  in  1  1 = use man_duty_i, bypassing scaling and the min/max clamp
pid_i  in  16  controller word, 0x0000..0xFFFF maps to 0..~100% duty
man_duty_i  in  CNT_W  manual duty in counts
period_i  in  CNT_W  PWM period in ticks
duty_min_i  in  CNT_W  lower duty clamp in counts
duty_max_i  in  CNT_W  upper duty clamp in counts
pwm_o  out  1  PWM output
period_done_o  out  1  one-clock pulse on the last tick of each period
duty_o  out  CNT_W  currently active (shadow) duty, for monitoring

Behaviour:
- Reset (reset_n_i=0, async): state=IDLE, cnt=0, per_sh=MIN_PERIOD, duty_sh=0, duty_calc=0. Outputs pwm_o=0, period_done_o=0, duty_o=0.
- duty_calc is registered every clock, so it has 1-clock latency from the inputs:
  - Manual mode: src = man_duty_i.
  - Normal mode: src = (pid_i * per_in) >> 16, using a full 32-bit product and keeping the upper 16 bits. per_in = max(period_i, MIN_PERIOD).
  - Normal mode clamp: src = max(src, duty_min_i), then min(src, duty_max_i). If min > max, max wins.
  - Both modes: finally duty_calc = min(src, per_in).
- States:
  - IDLE: cnt=0, pwm_o=0. On a clock with enable_i=1 and clk_en_i=1: load per_sh=per_in and duty_sh=duty_calc, set cnt=0, go to RUN.
  - RUN: on each clk_en_i=1 clock:
    - If cnt == per_sh-1: cnt<=0, per_sh<=per_in, duty_sh<=duty_calc, period_done_o<=1 for that clock only.
    - Else cnt<=cnt+1.
    - On clocks with clk_en_i=0, all state holds and period_done_o=0.
  - RUN to IDLE: enable_i=0 takes effect on the next clock, regardless of clk_en_i. It is immediate, with no finishing of the current period: cnt<=0 and pwm_o<=0.
- pwm_o is registered: pwm_o <= (state==RUN && cnt < duty_sh). It lags the counter by one clock.
  - duty_sh=0 gives constant low.
  - duty_sh=per_sh gives constant high, with no glitch across the boundary.
- duty_o = duty_sh.
- Mid-period changes to pid_i, man_duty_i, period_i, min/max or man_control_i do not affect the current period. They are sampled only at the boundary tick, or at the IDLE to RUN transition.
- A period of P ticks produces exactly duty_sh high ticks and P-duty_sh low ticks, contiguous, high first.
- The counter never wraps past per_sh-1. Maximum period is 2^CNT_W-1.
- Reset asserted mid-period: all outputs go to reset values immediately, without waiting for a clock edge.
- After reset release, stay IDLE until the first enable_i&clk_en_i clock.

Test Plan:
- clk_en_i=1, enable_i=1, period_i=100, pid_i=0x8000, min=0, max=100 -> duty_o=50; pwm_o 50 clocks high, 50 low; period_done_o pulses every 100 clocks.
- period_i=100, min=10, max=80: pid_i=0x0000 -> duty_o=10; pid_i=0xFFFF -> duty_o=80. With min=90, max=20 -> duty_o=20.
- man_control_i=1, man_duty_i=150, period_i=100 -> duty_o=100, pwm_o constant high. man_duty_i=0 -> pwm_o constant low.
- In RUN with duty 50, change pid_i to 0x4000 at cnt=10 -> current period still 50 high; next period 25 high; duty_o changes on the period_done_o clock.
- clk_en_i high 1 clock in 4, period_i=10, pid_i=0x8000 -> 40-clock period with 20 clocks high; period_done_o is 1 clock wide. period_i=0 or 1 -> 2-tick period.
- Assert reset_n_i low at cnt=37, between clock edges -> pwm_o, duty_o and period_done_o are 0 before the next edge. Separately, drop enable_i mid-period -> pwm_o=0 on the next clock, and the restart begins a fresh period from cnt=0.
